// File: rtl/traffic_timed_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_timed_ctrl_if
//  Description : Sensor/button inputs and lamp outputs of the timed
//                intersection controller.
//  Revision    : 1.0
// ============================================================================
interface traffic_timed_ctrl_if;
    logic       x;
    logic       ped_req;
    logic [2:0] Hryg;
    logic [2:0] Cryg;
    logic       walk;
    logic [2:0] state_o;

    modport master (
        output x,
        output ped_req,
        input  Hryg,
        input  Cryg,
        input  walk,
        input  state_o
    );

    modport slave (
        input  x,
        input  ped_req,
        output Hryg,
        output Cryg,
        output walk,
        output state_o
    );
endinterface
`default_nettype wire

// File: rtl/traffic_timed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_timed_ctrl
//  Description : Timed highway/side-road controller with all-red clearance,
//                capped side green and a latched pedestrian walk phase.
//  Revision    : 1.0
// ============================================================================
module traffic_timed_ctrl #(
    parameter int CNT_W          = 8,
    parameter int MIN_HWY_GREEN  = 8,
    parameter int YELLOW_T       = 3,
    parameter int ALL_RED_T      = 1,
    parameter int MAX_SIDE_GREEN = 10,
    parameter int WALK_T         = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    traffic_timed_ctrl_if.slave  bus
);

    localparam logic [2:0] c_HG  = 3'd0;
    localparam logic [2:0] c_HY  = 3'd1;
    localparam logic [2:0] c_AR1 = 3'd2;
    localparam logic [2:0] c_CG  = 3'd3;
    localparam logic [2:0] c_CY  = 3'd4;
    localparam logic [2:0] c_AR2 = 3'd5;

    // Terminal counts: a phase of duration D exits when the timer reads D-1.
    localparam logic [CNT_W-1:0] c_HG_LAST   = CNT_W'(MIN_HWY_GREEN - 1);
    localparam logic [CNT_W-1:0] c_Y_LAST    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] c_AR_LAST   = CNT_W'(ALL_RED_T - 1);
    localparam logic [CNT_W-1:0] c_CG_LAST   = CNT_W'(MAX_SIDE_GREEN - 1);
    localparam logic [CNT_W-1:0] c_WALK_LAST = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ped_pend;
    logic             r_walk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_HG;
            r_cnt      <= '0;
            r_ped_pend <= 1'b0;
            r_walk     <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (!(&r_cnt)) begin
                r_cnt <= r_cnt + c_ONE;
            end

            // A request arriving on the grant edge is served now, not re-latched.
            if (r_state == c_AR1 && w_next == c_CG) begin
                r_walk     <= r_ped_pend | bus.ped_req;
                r_ped_pend <= 1'b0;
            end else begin
                if (bus.ped_req) begin
                    r_ped_pend <= 1'b1;
                end
                if (w_next != c_CG) begin
                    r_walk <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_HG: begin
                if (r_cnt >= c_HG_LAST && (bus.x || r_ped_pend)) begin
                    w_next = c_HY;
                end
            end
            c_HY: begin
                if (r_cnt == c_Y_LAST) begin
                    w_next = c_AR1;
                end
            end
            c_AR1: begin
                if (r_cnt == c_AR_LAST) begin
                    w_next = c_CG;
                end
            end
            c_CG: begin
                // Side green ends at the cap, or once the road is empty and
                // any granted walk has had its minimum time.
                if (r_cnt == c_CG_LAST ||
                    (!bus.x && (!r_walk || r_cnt >= c_WALK_LAST))) begin
                    w_next = c_CY;
                end
            end
            c_CY: begin
                if (r_cnt == c_Y_LAST) begin
                    w_next = c_AR2;
                end
            end
            c_AR2: begin
                if (r_cnt == c_AR_LAST) begin
                    w_next = c_HG;
                end
            end
            default: w_next = c_HG;
        endcase
    end

    always_comb begin
        bus.Hryg    = 3'b100;
        bus.Cryg    = 3'b100;
        bus.walk    = 1'b0;
        bus.state_o = r_state;
        case (r_state)
            c_HG:  bus.Hryg = 3'b001;
            c_HY:  bus.Hryg = 3'b010;
            c_CG: begin
                bus.Cryg = 3'b001;
                bus.walk = r_walk;
            end
            c_CY:  bus.Cryg = 3'b010;
            default: begin
                bus.Hryg = 3'b100;
                bus.Cryg = 3'b100;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_timed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_timed_ctrl
//  Description : Directed scoreboard bench for the timed intersection controller.
//  Revision    : 1.0
// ============================================================================
module tb_traffic_timed_ctrl;

    localparam logic [2:0] c_HG  = 3'd0;
    localparam logic [2:0] c_HY  = 3'd1;
    localparam logic [2:0] c_AR1 = 3'd2;
    localparam logic [2:0] c_CG  = 3'd3;
    localparam logic [2:0] c_CY  = 3'd4;
    localparam logic [2:0] c_AR2 = 3'd5;

    logic clk;
    logic rst;
    traffic_timed_ctrl_if bus();

    traffic_timed_ctrl #(
        .CNT_W(8), .MIN_HWY_GREEN(8), .YELLOW_T(3),
        .ALL_RED_T(1), .MAX_SIDE_GREEN(10), .WALK_T(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected entry: {state, Hryg, Cryg, walk}
    logic [9:0] q[$];
    int         n_cmp = 0;
    int         n_mis = 0;
    int         cyc_no = 0;
    string      tname = "init";

    function automatic logic [5:0] lamps(input logic [2:0] st);
        case (st)
            c_HG:    lamps = {3'b001, 3'b100};
            c_HY:    lamps = {3'b010, 3'b100};
            c_CG:    lamps = {3'b100, 3'b001};
            c_CY:    lamps = {3'b100, 3'b010};
            default: lamps = {3'b100, 3'b100};
        endcase
    endfunction

    always @(negedge clk) begin
        logic [9:0] e;
        logic [9:0] a;
        if (q.size() != 0) begin
            e = q.pop_front();
            a = {bus.state_o, bus.Hryg, bus.Cryg, bus.walk};
            n_cmp++;
            if (a !== e) begin
                n_mis++;
                $display("FAIL %s cycle %0d: got st=%0d H=%b C=%b walk=%b, want st=%0d H=%b C=%b walk=%b",
                         tname, cyc_no, a[9:7], a[6:4], a[3:1], a[0],
                         e[9:7], e[6:4], e[3:1], e[0]);
            end
        end
    end

    // Drive this cycle's inputs, record what the DUT must show now, then advance.
    task automatic cyc(input logic xv, input logic pv, input logic [2:0] st, input logic w);
        bus.x       = xv;
        bus.ped_req = pv;
        q.push_back({st, lamps(st), w});
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic phase(input logic xv, input logic pv, input logic [2:0] st,
                         input int n, input logic w);
        for (int i = 0; i < n; i++) cyc(xv, pv, st, w);
    endtask

    task automatic do_reset(input string name);
        tname       = name;
        rst         = 1'b1;
        bus.x       = 1'b0;
        bus.ped_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst    = 1'b0;
        cyc_no = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.x       = 1'b0;
        bus.ped_req = 1'b0;

        // Idle: highway green forever.
        do_reset("idle");
        phase(0, 0, c_HG, 50, 0);

        // Side car always present: full cycle with side green at its cap.
        do_reset("car_held");
        for (int r = 0; r < 2; r++) begin
            phase(1, 0, c_HG, 8, 0);
            phase(1, 0, c_HY, 3, 0);
            phase(1, 0, c_AR1, 1, 0);
            phase(1, 0, c_CG, 10, 0);
            phase(1, 0, c_CY, 3, 0);
            phase(1, 0, c_AR2, 1, 0);
        end
        phase(1, 0, c_HG, 8, 0);
        phase(1, 0, c_HY, 1, 0);

        // Car leaves before minimum green: no phase change.
        do_reset("car_brief");
        phase(0, 0, c_HG, 2, 0);
        phase(1, 0, c_HG, 2, 0);
        phase(0, 0, c_HG, 30, 0);

        // Pedestrian pulse alone: walk phase of exactly WALK_T cycles.
        do_reset("ped_only");
        cyc(0, 0, c_HG, 0);
        cyc(0, 1, c_HG, 0);
        phase(0, 0, c_HG, 6, 0);
        phase(0, 0, c_HY, 3, 0);
        phase(0, 0, c_AR1, 1, 0);
        phase(0, 0, c_CG, 4, 1);
        phase(0, 0, c_CY, 3, 0);
        phase(0, 0, c_AR2, 1, 0);
        phase(0, 0, c_HG, 20, 0);

        // Request during a non-walk side green is granted on the next one.
        do_reset("ped_mid_cg");
        phase(1, 0, c_HG, 8, 0);
        phase(1, 0, c_HY, 3, 0);
        phase(1, 0, c_AR1, 1, 0);
        phase(1, 0, c_CG, 4, 0);
        cyc(1, 1, c_CG, 0);
        phase(1, 0, c_CG, 5, 0);
        phase(1, 0, c_CY, 3, 0);
        phase(1, 0, c_AR2, 1, 0);
        phase(1, 0, c_HG, 8, 0);
        phase(1, 0, c_HY, 3, 0);
        phase(1, 0, c_AR1, 1, 0);
        phase(1, 0, c_CG, 10, 1);
        phase(1, 0, c_CY, 3, 0);
        phase(1, 0, c_AR2, 1, 0);

        // Reset during walk with a request pending discards everything.
        do_reset("rst_in_cg");
        cyc(0, 0, c_HG, 0);
        cyc(0, 1, c_HG, 0);
        phase(0, 0, c_HG, 6, 0);
        phase(0, 0, c_HY, 3, 0);
        phase(0, 0, c_AR1, 1, 0);
        cyc(0, 1, c_CG, 1);
        rst = 1'b1;
        cyc(0, 0, c_CG, 1);
        rst = 1'b0;
        phase(0, 0, c_HG, 20, 0);

        @(negedge clk);
        #1;
        tname = "drain";
        n_cmp++;
        if (q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: got %0d entries left, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
